serial_word_loader: RTL and testbench
=====================================

// Module: serial_word_loader
// PURPOSE
//   Deserialises a bit-serial stream into WIDTH-bit words and drives the
//   D/wen write port of the downstream `register` block.
//   Accepts one bit per cycle over a valid/ready handshake.
//   Presents each completed word on d_out with a single-cycle wen pulse.
//   Supports frame abort and counts committed words for debug.
// PARAMETERS
//   WIDTH      8   word width; must match the downstream register WIDTH (>=1)
//   MSB_FIRST  1   1: first accepted bit lands in d_out[WIDTH-1]; 0: in d_out[0]
//   CNT_W      16  width of word_count
// PORTS
//   clk         input   1        rising-edge clock
//   rst         input   1        reset, asynchronous, active-high
//   s_valid     input   1        serial bit valid
//   s_bit       input   1        serial data bit
//   s_ready     output  1        loader can accept a bit this cycle
//   abort       input   1        synchronous discard of partial word
//   d_out       output  WIDTH    assembled word; connects to register D
//   wen         output  1        one-cycle write strobe; connects to register wen
//   busy        output  1        partial word in progress (state SHIFT)
//   word_count  output  CNT_W    number of committed words, wraps modulo 2^CNT_W
// BEHAVIOUR
//   Reset (async, active-high): state=IDLE, shift reg=0, d_out=0, wen=0,
//     busy=0, word_count=0, bit counter=0. s_ready=1 once rst deasserts.
//   Accept: a bit is taken on a rising edge when s_valid & s_ready.
//   States:
//     IDLE   s_ready=1, busy=0.
//            On accept: store bit and set cnt=1.
//            Go to SHIFT; go to COMMIT instead if WIDTH==1.
//     SHIFT  s_ready=1, busy=1.
//            On accept: shift in bit and increment cnt.
//            When cnt becomes WIDTH, go to COMMIT.
//            No accept: hold all state.
//     COMMIT s_ready=0, busy=0, wen=1 for exactly this cycle.
//            d_out already holds the full word; word_count increments.
//            cnt clears. Always returns to IDLE next cycle.
//   Shift order:
//     MSB_FIRST=1: sr <= {sr[WIDTH-2:0], s_bit}.
//     MSB_FIRST=0: sr <= {s_bit, sr[WIDTH-1:1]}.
//   d_out: updates only on the edge that enters COMMIT.
//     Stable at all other times, so the register never sees a partial word.
//   Latency: wen is high in the cycle after the edge accepting bit WIDTH.
//     Minimum word period is WIDTH+1 cycles.
//   abort in IDLE or SHIFT:
//     Discards the partial word, clears cnt, state=IDLE.
//     No wen pulse. d_out and word_count are unchanged.
//     abort has priority over a simultaneous accept, which is dropped.
//   abort in COMMIT: ignored; the commit completes.
//   s_valid during COMMIT: not accepted (s_ready=0); upstream holds the bit.
//   word_count wraps from 2^CNT_W-1 to 0 with no flag.
//   rst mid-word: everything returns to reset values immediately.
//     No wen is produced for the interrupted word.
//   Counter width: cnt is $clog2(WIDTH+1) bits; it never exceeds WIDTH.
// TESTING
//   1. WIDTH=8, MSB_FIRST=1, continuous bits 1,0,1,0,0,1,0,1
//      -> d_out=8'hA5 and wen=1 for one cycle 9 cycles after first accept;
//      word_count=1.
//   2. Same bits with MSB_FIRST=0 -> d_out=8'hA5 bit-reversed = 8'hA5.
//      Repeat with bits 1,1,0,0,0,0,0,0 -> d_out=8'h03.
//   3. Send 3 bits, pulse abort, then send byte 8'h3C
//      -> single wen with d_out=8'h3C; word_count=1; no wen at abort.
//   4. Hold s_valid=1 across COMMIT -> s_ready=0 that cycle.
//      The next word starts on the following cycle with no bit lost.
//      Back-to-back words 8'hFF, 8'h00 commit 9 cycles apart.
//   5. Assert rst after 5 bits -> wen=0, d_out=0, busy=0 at once.
//      Then 8'h81 after release -> d_out=8'h81.
//   6. CNT_W=2, commit 5 words -> word_count sequence 1,2,3,0,1.
//      Chained to register: Q follows d_out one cycle after wen.

Source files
------------

// File: rtl/serial_word_loader.sv
// Bit-serial to parallel word loader driving the D/wen port of a downstream register.
// A word is assembled from WIDTH accepted bits, then presented on d_out with a one-cycle wen.
module serial_word_loader #(
    parameter int WIDTH     = 8,
    parameter bit MSB_FIRST = 1'b1,
    parameter int CNT_W     = 16
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             s_valid,
    input  logic             s_bit,
    output logic             s_ready,
    input  logic             abort,
    output logic [WIDTH-1:0] d_out,
    output logic             wen,
    output logic             busy,
    output logic [CNT_W-1:0] word_count
);

    localparam int CW = $clog2(WIDTH + 1);
    localparam logic [CW-1:0] CNT_LAST = CW'(WIDTH - 1);

    localparam logic [1:0] S_IDLE   = 2'd0;
    localparam logic [1:0] S_SHIFT  = 2'd1;
    localparam logic [1:0] S_COMMIT = 2'd2;

    logic [1:0]       state;
    logic [WIDTH-1:0] sr;
    logic [WIDTH-1:0] sr_next;
    logic [CW-1:0]    cnt;
    logic             accept;

    generate
        if (WIDTH == 1) begin : g_w1
            assign sr_next = s_bit;
        end else if (MSB_FIRST) begin : g_msb
            assign sr_next = {sr[WIDTH-2:0], s_bit};
        end else begin : g_lsb
            assign sr_next = {s_bit, sr[WIDTH-1:1]};
        end
    endgenerate

    assign s_ready = (state != S_COMMIT);
    assign accept  = s_valid && s_ready;
    assign wen     = (state == S_COMMIT);
    assign busy    = (state == S_SHIFT);

    // d_out and word_count only move on the edge that enters COMMIT, so the
    // downstream register never observes a partially assembled word.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state      <= S_IDLE;
            sr         <= '0;
            d_out      <= '0;
            cnt        <= '0;
            word_count <= '0;
        end else begin
            case (state)
                S_IDLE: begin
                    if (abort) begin
                        cnt <= '0;
                    end else if (accept) begin
                        sr  <= sr_next;
                        cnt <= CW'(1);
                        if (WIDTH == 1) begin
                            state      <= S_COMMIT;
                            d_out      <= sr_next;
                            word_count <= word_count + CNT_W'(1);
                        end else begin
                            state <= S_SHIFT;
                        end
                    end
                end
                S_SHIFT: begin
                    if (abort) begin
                        cnt   <= '0;
                        state <= S_IDLE;
                    end else if (accept) begin
                        sr  <= sr_next;
                        cnt <= cnt + CW'(1);
                        if (cnt == CNT_LAST) begin
                            state      <= S_COMMIT;
                            d_out      <= sr_next;
                            word_count <= word_count + CNT_W'(1);
                        end
                    end
                end
                S_COMMIT: begin
                    cnt   <= '0;
                    state <= S_IDLE;
                end
                default: begin
                    cnt   <= '0;
                    state <= S_IDLE;
                end
            endcase
        end
    end

endmodule

// File: tb/tb_serial_word_loader.sv
// Scoreboard bench for serial_word_loader: two instances (MSB-first with a 2-bit word
// counter, LSB-first with a 16-bit counter) share one randomized serial stream.
module tb_serial_word_loader;

    logic       clk = 1'b0;
    logic       rst = 1'b1;
    logic       s_valid = 1'b0;
    logic       s_bit = 1'b0;
    logic       abort = 1'b0;
    logic       s_ready_a, s_ready_b, wen_a, wen_b, busy_a, busy_b;
    logic [7:0] d_out_a, d_out_b;
    logic [1:0] word_count_a;
    logic [15:0] word_count_b;
    logic [7:0] q_a;

    always #5 clk = ~clk;

    serial_word_loader #(.WIDTH(8), .MSB_FIRST(1'b1), .CNT_W(2)) dut_a (
        .clk(clk), .rst(rst), .s_valid(s_valid), .s_bit(s_bit), .s_ready(s_ready_a),
        .abort(abort), .d_out(d_out_a), .wen(wen_a), .busy(busy_a), .word_count(word_count_a)
    );

    serial_word_loader #(.WIDTH(8), .MSB_FIRST(1'b0), .CNT_W(16)) dut_b (
        .clk(clk), .rst(rst), .s_valid(s_valid), .s_bit(s_bit), .s_ready(s_ready_b),
        .abort(abort), .d_out(d_out_b), .wen(wen_b), .busy(busy_b), .word_count(word_count_b)
    );

    // downstream register fed by dut_a
    always_ff @(posedge clk or posedge rst) begin
        if (rst) q_a <= '0;
        else if (wen_a) q_a <= d_out_a;
    end

    typedef struct packed {
        logic [7:0]  wa;
        logic [7:0]  wb;
        logic [15:0] ca;
        logic [15:0] cb;
        logic [31:0] due;
    } exp_t;

    exp_t        sb[$];
    int          n_checks = 0;
    int          n_fail = 0;
    logic [31:0] cyc = 0;

    // reference model state
    logic        bits[8];
    int          nbits = 0;
    bit          in_commit = 0;
    int unsigned total = 0;
    logic [7:0]  last_a = 0, last_b = 0;
    bit          pend = 0;
    exp_t        pend_e;

    always @(posedge clk) cyc <= cyc + 1;

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0h expected %0h at cycle %0d", name, act, exp, cyc);
        end
    endtask

    task automatic model_reset();
        nbits = 0;
        in_commit = 0;
        total = 0;
        last_a = 0;
        last_b = 0;
        pend = 0;
        sb.delete();
    endtask

    // One clock of stimulus; the model decides what the edge should do.
    task automatic step(input logic v, input logic b, input logic a);
        exp_t e;
        @(negedge clk);
        s_valid = v;
        s_bit = b;
        abort = a;
        check("s_ready_a", 32'(s_ready_a), 32'(!in_commit));
        check("s_ready_b", 32'(s_ready_b), 32'(!in_commit));
        check("busy_a", 32'(busy_a), 32'(!in_commit && nbits > 0));
        if (in_commit) begin
            in_commit = 0;
            nbits = 0;
        end else if (a) begin
            nbits = 0;
        end else if (v) begin
            bits[nbits] = b;
            nbits++;
            if (nbits == 8) begin
                e = '0;
                for (int i = 0; i < 8; i++) begin
                    e.wa[7-i] = bits[i];
                    e.wb[i] = bits[i];
                end
                total++;
                e.ca = 16'(total % 4);
                e.cb = 16'(total % 65536);
                e.due = cyc + 1;
                sb.push_back(e);
                in_commit = 1;
                nbits = 0;
            end
        end
    endtask

    task automatic send_word(input logic [7:0] w);
        for (int i = 7; i >= 0; i--) begin
            step(1'b1, w[i], 1'b0);
            if (in_commit && nbits == 0 && i != 0) i = i; // never true mid-word
        end
    endtask

    task automatic idle(input int n);
        for (int i = 0; i < n; i++) step(1'b0, 1'b0, 1'b0);
    endtask

    // monitor: pops the scoreboard whenever a DUT presents a write strobe
    initial begin
        exp_t e;
        forever begin
            @(posedge clk);
            #1;
            if (rst) continue;
            check("wen_b_matches_a", 32'(wen_b), 32'(wen_a));
            if (pend) begin
                check("wen_single_cycle", 32'(wen_a), 32'(0));
                check("word_count_a", 32'(word_count_a), 32'(pend_e.ca));
                check("word_count_b", 32'(word_count_b), 32'(pend_e.cb));
                check("register_q", 32'(q_a), 32'(pend_e.wa));
                pend = 0;
            end else if (wen_a) begin
                if (sb.size() == 0) begin
                    n_checks++;
                    n_fail++;
                    $display("FAIL spurious_wen: got wen=1 expected no write at cycle %0d", cyc);
                end else begin
                    e = sb.pop_front();
                    check("d_out_a", 32'(d_out_a), 32'(e.wa));
                    check("d_out_b", 32'(d_out_b), 32'(e.wb));
                    check("wen_latency", cyc, e.due);
                    last_a = e.wa;
                    last_b = e.wb;
                    pend_e = e;
                    pend = 1;
                end
                continue;
            end
            if (!wen_a) begin
                check("d_out_a_stable", 32'(d_out_a), 32'(last_a));
                check("d_out_b_stable", 32'(d_out_b), 32'(last_b));
                if (sb.size() > 0 && sb[0].due < cyc) begin
                    e = sb.pop_front();
                    n_checks++;
                    n_fail++;
                    $display("FAIL missed_wen: got no write expected word %0h at cycle %0d", e.wa, e.due);
                end
            end
        end
    end

    initial begin
        #1;
        check("rst_wen", 32'(wen_a), 32'(0));
        check("rst_d_out", 32'(d_out_a), 32'(0));
        check("rst_busy", 32'(busy_a), 32'(0));
        check("rst_word_count", 32'(word_count_b), 32'(0));
        @(negedge clk);
        @(negedge clk);
        rst = 1'b0;
        #1;
        check("s_ready_after_rst", 32'(s_ready_a), 32'(1));

        send_word(8'hA5);
        idle(3);
        send_word(8'hC0);
        idle(3);
        for (int i = 0; i < 3; i++) step(1'b1, 1'($urandom), 1'b0);
        step(1'b0, 1'b0, 1'b1);
        send_word(8'h3C);
        idle(2);
        // s_valid held high across the commit: the next word must lose no bit
        send_word(8'hFF);
        step(1'b1, 1'b0, 1'b0);
        for (int i = 0; i < 8; i++) step(1'b1, 1'b0, 1'b0);
        idle(2);
        // abort arriving during COMMIT is ignored
        for (int i = 0; i < 8; i++) step(1'b1, 1'b1, 1'b0);
        step(1'b1, 1'b0, 1'b1);
        idle(2);

        for (int i = 0; i < 5; i++) step(1'b1, 1'b1, 1'b0);
        @(negedge clk);
        s_valid = 1'b0;
        rst = 1'b1;
        #1;
        check("midword_rst_wen", 32'(wen_a), 32'(0));
        check("midword_rst_d_out", 32'(d_out_a), 32'(0));
        check("midword_rst_busy", 32'(busy_a), 32'(0));
        check("midword_rst_count", 32'(word_count_a), 32'(0));
        model_reset();
        @(negedge clk);
        rst = 1'b0;
        send_word(8'h81);
        idle(2);

        for (int i = 0; i < 800; i++)
            step(1'($urandom_range(0, 9) < 7), 1'($urandom), 1'($urandom_range(0, 39) == 0));
        idle(12);
        check("scoreboard_drained", 32'(sb.size()), 32'(0));
        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule
